// File: rtl/cmd_decoder_if.sv
// Byte-in / command-out bundle for cmd_decoder.
// master = byte source and command consumer; slave = the decoder.
interface cmd_decoder_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [47:0] write_read_req;
  logic        wr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        hdr_err;
  logic        to_err;
  logic        ovr_err;

  modport master (
    output rx_data, rx_valid, cmd_ready,
    input  write_read_req, wr, cmd_valid, hdr_err, to_err, ovr_err
  );

  modport slave (
    input  rx_data, rx_valid, cmd_ready,
    output write_read_req, wr, cmd_valid, hdr_err, to_err, ovr_err
  );
endinterface

// File: rtl/cmd_decoder.sv
// Assembles 7-byte UART frames (header + 6 payload bytes, MSB first) into a held command.
// Command appears 1 cycle after the last byte; holds until cmd_ready, dropping bytes meanwhile.
module cmd_decoder #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input logic         clk,
  input logic         rst,
  cmd_decoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, HOLD} state_t;

  localparam logic [15:0] TO_LAST = TIMEOUT_CYCLES - 16'd1;

  state_t      state;
  logic [47:0] req_q;
  logic        wr_q;
  logic        cmd_valid_q;
  logic        hdr_err_q;
  logic        to_err_q;
  logic        ovr_err_q;
  logic [2:0]  byte_cnt;
  logic [15:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_q       <= 48'h0;
      wr_q        <= 1'b0;
      cmd_valid_q <= 1'b0;
      hdr_err_q   <= 1'b0;
      to_err_q    <= 1'b0;
      ovr_err_q   <= 1'b0;
      byte_cnt    <= 3'd0;
      to_cnt      <= 16'd0;
    end else begin
      hdr_err_q <= 1'b0;
      to_err_q  <= 1'b0;
      ovr_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == 8'h02 || bus.rx_data == 8'h03) begin
              wr_q     <= (bus.rx_data == 8'h02);
              byte_cnt <= 3'd0;
              to_cnt   <= 16'd0;
              state    <= PAYLOAD;
            end else begin
              hdr_err_q <= 1'b1;
            end
          end
        end
        PAYLOAD: begin
          // A byte arriving on the threshold cycle takes priority over the timeout.
          if (bus.rx_valid) begin
            req_q    <= {req_q[39:0], bus.rx_data};
            byte_cnt <= byte_cnt + 3'd1;
            to_cnt   <= 16'd0;
            if (byte_cnt == 3'd5) begin
              state       <= HOLD;
              cmd_valid_q <= 1'b1;
            end
          end else if (to_cnt == TO_LAST) begin
            state    <= IDLE;
            to_err_q <= 1'b1;
            byte_cnt <= 3'd0;
            to_cnt   <= 16'd0;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        HOLD: begin
          if (bus.rx_valid) begin
            ovr_err_q <= 1'b1;
          end
          if (bus.cmd_ready) begin
            state       <= IDLE;
            cmd_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.write_read_req = req_q;
  assign bus.wr             = wr_q;
  assign bus.cmd_valid      = cmd_valid_q;
  assign bus.hdr_err        = hdr_err_q;
  assign bus.to_err         = to_err_q;
  assign bus.ovr_err        = ovr_err_q;

endmodule

// File: tb/tb_cmd_decoder.sv
// Directed and randomized bench for cmd_decoder against a frame-level reference model.
module tb_cmd_decoder;

  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  cmd_decoder_if bus ();

  cmd_decoder #(.TIMEOUT_CYCLES(16'd8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: bytes of the frame in progress, idle gap, pending command.
  logic [7:0]  frame_q[$];
  bit          collecting = 0;
  bit          pending    = 0;
  int          idle_gap   = 0;
  logic [47:0] m_req      = 48'h0;
  logic        m_wr       = 1'b0;
  logic        m_hdr, m_to, m_ovr;

  task automatic model_edge(input bit r, input bit v, input logic [7:0] d, input bit rdy);
    m_hdr = 0; m_to = 0; m_ovr = 0;
    if (r) begin
      collecting = 0; pending = 0; idle_gap = 0;
      frame_q.delete();
      m_req = 48'h0; m_wr = 1'b0;
    end else if (pending) begin
      if (v)   m_ovr = 1;
      if (rdy) pending = 0;
    end else if (collecting) begin
      if (v) begin
        frame_q.push_back(d);
        idle_gap = 0;
        if (frame_q.size() == 6) begin
          m_req = {frame_q[0], frame_q[1], frame_q[2], frame_q[3], frame_q[4], frame_q[5]};
          pending    = 1;
          collecting = 0;
        end
      end else begin
        idle_gap++;
        if (idle_gap == T) begin
          m_to       = 1;
          collecting = 0;
          frame_q.delete();
        end
      end
    end else if (v) begin
      if (d == 8'h02 || d == 8'h03) begin
        collecting = 1;
        idle_gap   = 0;
        m_wr       = (d == 8'h02);
        frame_q.delete();
      end else begin
        m_hdr = 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit rdy, input string tag);
    bus.rx_valid  = v;
    bus.rx_data   = d;
    bus.cmd_ready = rdy;
    @(posedge clk);
    model_edge(rst, v, d, rdy);
    #1;
    check({tag, ":flags"}, {60'h0, bus.cmd_valid, bus.hdr_err, bus.to_err, bus.ovr_err},
          {60'h0, pending, m_hdr, m_to, m_ovr});
    if (pending)
      check({tag, ":cmd"}, {15'h0, bus.wr, bus.write_read_req}, {15'h0, m_wr, m_req});
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [47:0] p, input bit rdy, input string tag);
    step(1, hdr, rdy, tag);
    for (int i = 5; i >= 0; i--) step(1, p[i*8 +: 8], rdy, tag);
  endtask

  task automatic idle(input int n, input bit rdy, input string tag);
    for (int i = 0; i < n; i++) step(0, 8'h00, rdy, tag);
  endtask

  initial begin
    bus.rx_valid = 0; bus.rx_data = 8'h00; bus.cmd_ready = 0;
    rst = 1;
    // Reset asserted together with a byte and cmd_ready: reset must win.
    step(1, 8'h02, 1, "reset");
    step(1, 8'h7E, 1, "reset");
    check("reset_all", {11'h0, bus.write_read_req, bus.wr, bus.cmd_valid, bus.hdr_err, bus.to_err, bus.ovr_err},
          64'h0);
    rst = 0;

    // Write frame consumed immediately.
    send_frame(8'h02, 48'h112233445566, 1, "write");
    check("write_req", {16'h0, bus.write_read_req}, {16'h0, 48'h112233445566});
    check("write_wr", {63'h0, bus.wr}, 64'h1);
    idle(2, 1, "write_drain");

    // Read frame held with cmd_ready low, an extra byte during hold.
    send_frame(8'h03, 48'hA0000000000F, 0, "read");
    idle(2, 0, "read_hold");
    step(1, 8'h55, 0, "read_ovr");
    check("read_ovr_pulse", {63'h0, bus.ovr_err}, 64'h1);
    check("read_held", {15'h0, bus.wr, bus.write_read_req}, {15'h0, 1'b0, 48'hA0000000000F});
    idle(2, 0, "read_hold2");
    step(1, 8'h66, 1, "read_xfer_ovr");
    check("xfer_ovr", {62'h0, bus.cmd_valid, bus.ovr_err}, 64'h1);
    idle(2, 0, "read_drain");

    // Bad header then a good frame.
    step(1, 8'h7E, 0, "badhdr");
    check("hdr_pulse", {63'h0, bus.hdr_err}, 64'h1);
    step(0, 8'h00, 0, "badhdr");
    send_frame(8'h02, 48'hDEADBEEF0102, 1, "after_bad");
    idle(1, 1, "after_bad");

    // Timeout after two payload bytes, then a full frame.
    step(1, 8'h02, 1, "to"); step(1, 8'h11, 1, "to"); step(1, 8'h22, 1, "to");
    idle(T - 1, 1, "to_wait");
    check("no_early_to", {63'h0, bus.to_err}, 64'h0);
    idle(1, 1, "to_fire");
    check("to_pulse", {63'h0, bus.to_err}, 64'h1);
    idle(2, 1, "to_after");
    send_frame(8'h03, 48'h0123456789AB, 1, "after_to");
    idle(1, 1, "after_to");

    // Bytes on the exact threshold cycle, payload containing header codes.
    step(1, 8'h02, 0, "thr");
    idle(T - 1, 0, "thr_gap"); step(1, 8'h02, 0, "thr_b1");
    idle(T - 1, 0, "thr_gap"); step(1, 8'h03, 0, "thr_b2");
    for (int i = 0; i < 4; i++) begin
      idle(T - 1, 0, "thr_gap");
      step(1, 8'h10 + 8'(i), 0, "thr_bn");
    end
    check("thr_req", {16'h0, bus.write_read_req}, {16'h0, 48'h020310111213});
    step(0, 8'h00, 1, "thr_xfer");
    idle(1, 0, "thr_drain");

    // Reset after the 4th byte of a frame.
    step(1, 8'h02, 0, "rst_mid"); step(1, 8'hAA, 0, "rst_mid");
    step(1, 8'hBB, 0, "rst_mid"); step(1, 8'hCC, 0, "rst_mid");
    rst = 1; step(0, 8'h00, 0, "rst_mid_pulse"); rst = 0;
    check("rst_mid_zero", {11'h0, bus.write_read_req, bus.wr, bus.cmd_valid, bus.hdr_err, bus.to_err, bus.ovr_err},
          64'h0);
    send_frame(8'h02, 48'hCAFEF00D1234, 1, "after_rst");
    idle(1, 1, "after_rst");

    // Randomized traffic, including gaps around the timeout threshold and rare resets.
    for (int n = 0; n < 3000; n++) begin
      int sel;
      logic [7:0] d;
      sel = int'($urandom_range(0, 99));
      rst = ($urandom_range(0, 299) == 0);
      d = 8'($urandom);
      if (sel < 20) d = 8'h02;
      else if (sel < 35) d = 8'h03;
      if (sel >= 97) begin
        rst = 0;
        idle(int'($urandom_range(T - 2, T + 1)), ($urandom_range(0, 1) == 1), "rnd_gap");
      end else begin
        step(($urandom_range(0, 2) != 0), d, ($urandom_range(0, 3) != 0), "rnd");
      end
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
